// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe
//   Writeback stage between EXE and the register file. Each accepted beat
//   has its result selected (ALU, extracted and extended memory load, or
//   link address) and is held in a 2-entry in-order skid buffer until the
//   register-file side takes it.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   in_valid     : upstream beat valid
//   in_ready     : registered; this stage accepts a beat this cycle
//   in_res_sel   : result source 0 ALU, 1 memory, 2 link, 3 ALU
//   in_reg_write : register-write request
//   in_dest      : destination register
//   in_alu       : ALU result
//   in_mem       : raw memory read word
//   in_link      : return address
//   in_ld_size   : 0 byte, 1 half, 2 word(32b), 3 full DATA_W
//   in_ld_signed : 1 sign-extend, 0 zero-extend
//   in_byte_off  : load address low bits
//   out_ready    : register-file side accepts a beat
//   out_valid    : writeback beat valid
//   wr_en        : register-file write strobe (suppressed for dest 0)
//   wr_dest      : write address (oldest entry)
//   wr_data      : write data (oldest entry)
//   retire_cnt   : number of emitted beats, wraps
module wb_stage_pipe #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned REG_AW = 5,
  parameter  int unsigned CNT_W  = 32,
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_res_sel,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_link,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_signed,
  input  logic [OFF_W-1:0]  in_byte_off,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_dest,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_in_ready;
  logic [CNT_W-1:0]  r_retire_cnt;

  // Slot 0 is always the oldest entry; slot 1 is only meaningful in S_TWO.
  logic [1:0][DATA_W-1:0] r_data;
  logic [1:0][REG_AW-1:0] r_dest;
  logic [1:0]             r_we;

  logic              w_accept;
  logic              w_emit;
  logic              w_out_valid;
  logic [OFF_W-1:0]  w_off_half;
  logic [OFF_W-1:0]  w_off_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;
  logic [DATA_W-1:0] w_mem_res;
  logic [DATA_W-1:0] w_result;

  // ---------------------------------------------------------------------------
  // Result formation
  // ---------------------------------------------------------------------------
  assign w_off_half = in_byte_off & ~OFF_W'(1);
  assign w_off_word = in_byte_off & ~OFF_W'(3);

  assign w_byte = in_mem[{in_byte_off, 3'b000} +: 8];
  assign w_half = in_mem[{w_off_half,  3'b000} +: 16];
  assign w_word = in_mem[{w_off_word,  3'b000} +: 32];

  // Fill the whole word with the extension bit, then overlay the lane.
  // For DATA_W=32 the word case already covers the full width, so size 3
  // and size 2 give the same value.
  always_comb begin
    w_mem_res = in_mem;
    case (in_ld_size)
      2'd0: begin
        w_mem_res      = {DATA_W{in_ld_signed & w_byte[7]}};
        w_mem_res[7:0] = w_byte;
      end
      2'd1: begin
        w_mem_res       = {DATA_W{in_ld_signed & w_half[15]}};
        w_mem_res[15:0] = w_half;
      end
      2'd2: begin
        w_mem_res       = {DATA_W{in_ld_signed & w_word[31]}};
        w_mem_res[31:0] = w_word;
      end
      default: w_mem_res = in_mem;
    endcase
  end

  always_comb begin
    w_result = in_alu;
    case (in_res_sel)
      2'd1:    w_result = w_mem_res;
      2'd2:    w_result = in_link;
      default: w_result = in_alu;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake and state machine
  // ---------------------------------------------------------------------------
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = in_valid & r_in_ready;
  assign w_emit      = w_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) w_state_nxt = S_ONE;
      end
      S_ONE: begin
        if (w_accept && !w_emit)      w_state_nxt = S_TWO;
        else if (!w_accept && w_emit) w_state_nxt = S_EMPTY;
      end
      S_TWO: begin
        if (w_emit) w_state_nxt = S_ONE;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // in_ready is registered from the next state, so it is already low in
  // S_TWO and no accept can arrive while both slots are full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != S_TWO);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_dest <= '0;
      r_we   <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_data[0] <= w_result;
            r_dest[0] <= in_dest;
            r_we[0]   <= in_reg_write;
          end
        end
        S_ONE: begin
          // On simultaneous accept and emit the new beat replaces the head.
          if (w_accept && w_emit) begin
            r_data[0] <= w_result;
            r_dest[0] <= in_dest;
            r_we[0]   <= in_reg_write;
          end else if (w_accept) begin
            r_data[1] <= w_result;
            r_dest[1] <= in_dest;
            r_we[1]   <= in_reg_write;
          end
        end
        S_TWO: begin
          if (w_emit) begin
            r_data[0] <= r_data[1];
            r_dest[0] <= r_dest[1];
            r_we[0]   <= r_we[1];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retire_cnt <= '0;
    end else if (w_emit) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready   = r_in_ready;
  assign out_valid  = w_out_valid;
  assign wr_en      = w_emit & r_we[0] & (r_dest[0] != '0);
  assign wr_dest    = r_dest[0];
  assign wr_data    = r_data[0];
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage_pipe.sv
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid;
  logic [1:0]  in_res_sel;
  logic        in_reg_write;
  logic [4:0]  in_dest;
  logic [31:0] in_alu, in_mem, in_link;
  logic [1:0]  in_ld_size;
  logic        in_ld_signed;
  logic [1:0]  in_byte_off;
  logic        out_ready;

  logic        in_ready, out_valid, wr_en;
  logic [4:0]  wr_dest;
  logic [31:0] wr_data;
  logic [31:0] retire_cnt;

  logic        c_in_ready, c_out_valid, c_wr_en;
  logic [4:0]  c_wr_dest;
  logic [31:0] c_wr_data;
  logic [3:0]  c_retire_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_stage_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_res_sel(in_res_sel), .in_reg_write(in_reg_write), .in_dest(in_dest),
    .in_alu(in_alu), .in_mem(in_mem), .in_link(in_link),
    .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .in_byte_off(in_byte_off), .out_ready(out_ready), .out_valid(out_valid),
    .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data), .retire_cnt(retire_cnt)
  );

  wb_stage_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_res_sel(in_res_sel), .in_reg_write(in_reg_write), .in_dest(in_dest),
    .in_alu(in_alu), .in_mem(in_mem), .in_link(in_link),
    .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .in_byte_off(in_byte_off), .out_ready(out_ready), .out_valid(c_out_valid),
    .wr_en(c_wr_en), .wr_dest(c_wr_dest), .wr_data(c_wr_data),
    .retire_cnt(c_retire_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 0; in_res_sel = 0; in_reg_write = 0; in_dest = 0;
    in_alu = 0; in_mem = 0; in_link = 0; in_ld_size = 0;
    in_ld_signed = 0; in_byte_off = 0; out_ready = 0;
  endtask

  task automatic set_beat(input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [31:0] link,
                          input logic [4:0] dest, input logic rw,
                          input logic [1:0] sz, input logic sg,
                          input logic [1:0] off);
    in_valid = 1; in_res_sel = sel; in_alu = alu; in_mem = mem;
    in_link = link; in_dest = dest; in_reg_write = rw;
    in_ld_size = sz; in_ld_signed = sg; in_byte_off = off;
  endtask

  // Leaves the DUT one edge past reset release, with in_ready high.
  task automatic do_reset;
    idle_inputs();
    rst = 0;
    #12;
    @(negedge clk);
    rst = 1;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 0;
    #2;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_dest !== 5'd0) begin n_fail++; $display("FAIL rst_wr_dest: got %0d want 0", wr_dest); end
    n_cmp++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
    n_cmp++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_retire: got %0d want 0", retire_cnt); end
    @(negedge clk);
    rst = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready_pre_edge: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready_post_edge: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_alu;
    do_reset();
    out_ready = 1;
    set_beat(2'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0400, 5'd7, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL alu_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL alu_wr_en: got %b want 1", wr_en); end
    n_cmp++; if (wr_dest !== 5'd7) begin n_fail++; $display("FAIL alu_wr_dest: got %0d want 7", wr_dest); end
    n_cmp++; if (wr_data !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_wr_data: got %h want 12345678", wr_data); end
    tick();
    n_cmp++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL alu_retire: got %0d want 1", retire_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drain: got %b want 0", out_valid); end
    // link source, then reserved select which falls back to ALU
    set_beat(2'd2, 32'h1111_1111, 32'h2222_2222, 32'h0000_1004, 5'd31, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    in_valid = 0;
    n_cmp++; if (wr_data !== 32'h0000_1004) begin n_fail++; $display("FAIL link_wr_data: got %h want 00001004", wr_data); end
    tick();
    set_beat(2'd3, 32'hA5A5_0F0F, 32'h2222_2222, 32'h0000_1004, 5'd9, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    in_valid = 0;
    n_cmp++; if (wr_data !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL sel3_wr_data: got %h want a5a50f0f", wr_data); end
    tick();
  endtask

  task automatic test_load;
    logic [1:0]  sz [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    logic        sg [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  of [10] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
    logic [31:0] ex [10] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF,
                             32'h0000_0001, 32'h0000_7F01, 32'h80FF_7F01, 32'h80FF_7F01,
                             32'h0000_00FF, 32'hFFFF_FFFF};
    do_reset();
    out_ready = 1;
    // One beat per cycle: each edge emits the previous beat and accepts the next.
    for (int i = 0; i < 10; i++) begin
      set_beat(2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 5'd3, 1'b1, sz[i], sg[i], of[i]);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || wr_data !== ex[i]) begin
        n_fail++;
        $display("FAIL load_%0d: got valid=%b data=%h want valid=1 data=%h", i, out_valid, wr_data, ex[i]);
      end
    end
    in_valid = 0;
    tick();
    n_cmp++; if (retire_cnt !== 32'd10) begin n_fail++; $display("FAIL load_retire: got %0d want 10", retire_cnt); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    out_ready = 0;
    set_beat(2'd0, 32'h0000_0011, 32'h0, 32'h0, 5'd1, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    set_beat(2'd0, 32'h0000_0022, 32'h0, 32'h0, 5'd2, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    set_beat(2'd0, 32'h0000_0033, 32'h0, 32'h0, 5'd3, 1'b1, 2'd0, 1'b0, 2'd0);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_wr_en: got %b want 0", wr_en); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || wr_data !== 32'h11 || wr_dest !== 5'd1) begin
      n_fail++; $display("FAIL b2b_hold: got valid=%b data=%h dest=%0d want 1/00000011/1", out_valid, wr_data, wr_dest);
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_third_held: got %b want 0", in_ready); end
    out_ready = 1;
    #1;
    n_cmp++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL b2b_release_wr_en: got %b want 1", wr_en); end
    tick();
    n_cmp++; if (wr_data !== 32'h22 || wr_dest !== 5'd2) begin
      n_fail++; $display("FAIL b2b_second: got data=%h dest=%0d want 00000022/2", wr_data, wr_dest);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_again: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_cmp++; if (wr_data !== 32'h33 || wr_dest !== 5'd3) begin
      n_fail++; $display("FAIL b2b_third: got data=%h dest=%0d want 00000033/3", wr_data, wr_dest);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    n_cmp++; if (retire_cnt !== 32'd3) begin n_fail++; $display("FAIL b2b_retire: got %0d want 3", retire_cnt); end
  endtask

  task automatic test_reg0;
    do_reset();
    out_ready = 1;
    set_beat(2'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd0, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reg0_wr_en: got valid=%b wr_en=%b want 1/0", out_valid, wr_en);
    end
    tick();
    n_cmp++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL reg0_retire: got %0d want 1", retire_cnt); end
    set_beat(2'd0, 32'h0000_0055, 32'h0, 32'h0, 5'd5, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || wr_en !== 1'b0) begin
      n_fail++; $display("FAIL nowrite_wr_en: got valid=%b wr_en=%b want 1/0", out_valid, wr_en);
    end
    tick();
    n_cmp++; if (retire_cnt !== 32'd2) begin n_fail++; $display("FAIL nowrite_retire: got %0d want 2", retire_cnt); end
  endtask

  task automatic test_async_reset;
    do_reset();
    out_ready = 1;
    set_beat(2'd0, 32'h0000_00AA, 32'h0, 32'h0, 5'd4, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    in_valid = 0;
    tick();
    out_ready = 0;
    set_beat(2'd0, 32'h0000_00BB, 32'h0, 32'h0, 5'd5, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    set_beat(2'd0, 32'h0000_00CC, 32'h0, 32'h0, 5'd6, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    in_valid = 0;
    n_cmp++; if (in_ready !== 1'b0 || retire_cnt !== 32'd1) begin
      n_fail++; $display("FAIL arst_pre: got in_ready=%b retire=%0d want 0/1", in_ready, retire_cnt);
    end
    #2;
    rst = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL arst_retire: got %0d want 0", retire_cnt); end
    n_cmp++; if (wr_data !== 32'h0 || wr_dest !== 5'd0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL arst_outputs: got data=%h dest=%0d in_ready=%b want 0/0/0", wr_data, wr_dest, in_ready);
    end
    @(negedge clk);
    rst = 1;
    out_ready = 1;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0 || wr_en !== 1'b0 || retire_cnt !== 32'd0) begin
      n_fail++; $display("FAIL arst_no_stale: got valid=%b wr_en=%b retire=%0d want 0/0/0", out_valid, wr_en, retire_cnt);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 17; i++) begin
      set_beat(2'd0, 32'(i), 32'h0, 32'h0, 5'(i), 1'b1, 2'd0, 1'b0, 2'd0);
      tick();
    end
    in_valid = 0;
    tick();
    n_cmp++; if (c_retire_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt4: got %0d want 1", c_retire_cnt); end
    n_cmp++; if (retire_cnt !== 32'd17) begin n_fail++; $display("FAIL wrap_cnt32: got %0d want 17", retire_cnt); end
    n_cmp++; if (c_out_valid !== 1'b0 || c_wr_en !== 1'b0 || c_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL wrap_ctrl4: got valid=%b wr_en=%b in_ready=%b want 0/0/1", c_out_valid, c_wr_en, c_in_ready);
    end
    n_cmp++; if (c_wr_data !== 32'd16 || c_wr_dest !== 5'd16) begin
      n_fail++; $display("FAIL wrap_last4: got data=%h dest=%0d want 00000010/16", c_wr_data, c_wr_dest);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_reg0();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the datapath width; legal values are 32 and 64.
REQ-002 Parameter REG_AW, default 5, SHALL set the register-file destination address width.
REQ-003 Parameter CNT_W, default 32, SHALL set the retire-counter width.
REQ-004 Derived OFF_W = log2(DATA_W/8) SHALL set the byte-offset width.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-006 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-007 in_valid  in  1  SHALL mark an upstream EXE/WB beat as valid.
REQ-008 in_ready  out  1  SHALL mark that this block accepts a beat this cycle.
REQ-009 in_res_sel  in  2  SHALL select the result source: 0 ALU, 1 memory, 2 link, 3 reserved (treated as ALU).
REQ-010 in_reg_write  in  1  SHALL be the register-write request of the beat.
REQ-011 in_dest  in  REG_AW  SHALL be the destination register of the beat.
REQ-012 in_alu, in_mem, in_link  in  DATA_W each  SHALL be the ALU result, the raw memory read word, and the return address.
REQ-013 in_ld_size  in  2  SHALL give the load size: 0 byte, 1 half, 2 word (32-bit), 3 full DATA_W.
REQ-014 in_ld_signed  in  1  SHALL select sign extension (1) or zero extension (0).
REQ-015 in_byte_off  in  OFF_W  SHALL be the load address low bits.
REQ-016 out_ready  in  1  SHALL be asserted by the register-file side when it accepts a beat.
REQ-017 out_valid  out  1  SHALL mark a valid writeback beat.
REQ-018 wr_en, wr_dest (REG_AW), wr_data (DATA_W)  out  SHALL be the register-file write strobe, address and data.
REQ-019 retire_cnt  out  CNT_W  SHALL count completed writeback beats.

Function
REQ-020 Accept SHALL occur when in_valid & in_ready; emit SHALL occur when out_valid & out_ready.
REQ-021 At accept, the result SHALL be formed combinationally from in_res_sel and stored; the block SHALL NOT re-sample input data after accept.
REQ-022 Memory result extraction: byte = lane in_byte_off; half = lane pair at in_byte_off with bit0 cleared; word = 4-byte group at in_byte_off with bits[1:0] cleared; full = in_mem unchanged. Lanes are little-endian.
REQ-023 Extracted byte, half and word SHALL be sign- or zero-extended to DATA_W per in_ld_signed; for DATA_W=32, size 3 SHALL equal size 2.
REQ-024 Storage SHALL be a 2-entry in-order skid buffer with states EMPTY, ONE, TWO.
REQ-025 in_ready SHALL be a registered output, equal to 1 in EMPTY and ONE and 0 in TWO.
REQ-026 Transitions: EMPTY->ONE on accept; ONE->TWO on accept without emit; ONE->EMPTY on emit without accept; ONE stays ONE on simultaneous accept and emit; TWO->ONE on emit.
REQ-027 out_valid SHALL be 1 in ONE and TWO; wr_dest and wr_data SHALL present the oldest entry.
REQ-028 Latency from accept to out_valid SHALL be exactly 1 cycle when the buffer was EMPTY.
REQ-029 wr_en SHALL equal out_valid & out_ready & stored reg_write & (stored dest != 0); writes to register 0 SHALL be suppressed but still SHALL count as retired.
REQ-030 retire_cnt SHALL increment by 1 on every emit and SHALL wrap modulo 2^CNT_W.
REQ-031 Output data SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-032 While rst=0: state EMPTY, in_ready=0, out_valid=0, wr_en=0, wr_dest=0, wr_data=0, retire_cnt=0.
REQ-033 The first rising clk after rst deasserts SHALL set in_ready=1.
REQ-034 Reset asserted mid-operation SHALL discard all buffered beats immediately, without waiting for a clock edge.

Verification
REQ-035 ALU beat, sel=0, alu=0x1234_5678, dest=7, out_ready=1 -> next cycle wr_en=1, wr_dest=7, wr_data=0x1234_5678, retire_cnt=1.
REQ-036 Load beat, mem=0x80FF_7F01, size=0, signed=1, off=1 -> wr_data=0x0000_007F; same beat with off=3 -> 0xFFFF_FF80; with size=1, signed=0, off=2 -> 0x0000_80FF.
REQ-037 out_ready=0 and 3 back-to-back beats offered -> 2 accepted, in_ready=0 on the next cycle, third beat held; raising out_ready -> beats emitted in order with data unchanged.
REQ-038 Beat with dest=0, reg_write=1 -> wr_en=0 while out_valid=1 and out_ready=1, and retire_cnt increments.
REQ-039 rst pulsed low while state is TWO -> out_valid=0 and retire_cnt=0 asynchronously; no stale beat emitted after release.
REQ-040 CNT_W=4, 17 emits -> retire_cnt=1.
